// File: rtl/led_pio_scheduler.sv
// Two-requester round-robin scheduler that turns LED commands into single-cycle
// Avalon-MM write strobes to the LED PIO. It keeps a shadow copy of the PIO output register.
module led_pio_scheduler #(
  parameter int GAP_CYCLES = 2,
  parameter int LED_W      = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_op,
  input  logic [LED_W-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_op,
  input  logic [LED_W-1:0] b_data,
  output logic [2:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  output logic [LED_W-1:0] shadow,
  output logic             busy
);

  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

  // Handshake: a command transfers at the rising edge where x_valid && x_ready.
  // Ready is only ever raised in IDLE, for the current winner, and never during reset.
  state_t           state, state_nxt;
  logic             last_b;
  logic             win_b;
  logic             accept;
  logic [1:0]       sel_op;
  logic [LED_W-1:0] sel_data;
  logic [1:0]       op_q;
  logic [LED_W-1:0] data_q;
  logic [CNT_W-1:0] gap_cnt;

  always_comb begin
    win_b = 1'b0;
    if (a_valid && b_valid) win_b = !last_b;
    else if (b_valid)       win_b = 1'b1;
  end

  assign accept   = (state == ST_IDLE) && reset_n && (a_valid || b_valid);
  assign a_ready  = accept && !win_b;
  assign b_ready  = accept && win_b;
  assign sel_op   = win_b ? b_op : a_op;
  assign sel_data = win_b ? b_data : a_data;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b     <= 1'b1;
      op_q       <= 2'd0;
      data_q     <= '0;
      address    <= 3'd0;
      writedata  <= 32'd0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      shadow     <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_b     <= win_b;
            op_q       <= sel_op;
            data_q     <= sel_data;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            case (sel_op)
              2'd0: begin address <= 3'd0; writedata <= 32'(sel_data); end
              2'd1: begin address <= 3'd4; writedata <= 32'(sel_data); end
              2'd2: begin address <= 3'd5; writedata <= 32'(sel_data); end
              // Toggle is issued as a full write of the flipped shadow value.
              default: begin address <= 3'd0; writedata <= 32'(shadow ^ sel_data); end
            endcase
          end
        end
        ST_WRITE: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          gap_cnt    <= GAP_LOAD;
          case (op_q)
            2'd1:    shadow <= shadow | data_q;
            2'd2:    shadow <= shadow & ~data_q;
            default: shadow <= writedata[LED_W-1:0];
          endcase
        end
        ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pio_scheduler.sv
// Bench for led_pio_scheduler: directed scenarios plus randomized dual-requester
// streams checked against a command-level model of the PIO register.
module tb_led_pio_scheduler;
  localparam int GAP = 2;
  localparam int LW  = 18;
  localparam int W   = 3 + 32 + LW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [1:0]    a_op = '0, b_op = '0;
  logic [LW-1:0] a_data = '0, b_data = '0;
  logic [2:0]    address;
  logic          chipselect, write_n, busy;
  logic [31:0]   writedata;
  logic [LW-1:0] shadow;

  led_pio_scheduler #(.GAP_CYCLES(GAP), .LED_W(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_data(b_data),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .shadow(shadow), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [LW-1:0] m_shadow = '0;
  bit            m_last_b = 1'b1;
  logic [W-1:0]  exp_q[$];

  // Command-level model: returns {address, writedata, shadow after the write}.
  function automatic logic [W-1:0] model_cmd(input logic [1:0] op, input logic [LW-1:0] d);
    logic [2:0]    a;
    logic [LW-1:0] v;
    case (op)
      2'd0:    begin a = 3'd0; v = d; m_shadow = d; end
      2'd1:    begin a = 3'd4; v = d; m_shadow = m_shadow | d; end
      2'd2:    begin a = 3'd5; v = d; m_shadow = m_shadow & ~d; end
      default: begin a = 3'd0; v = m_shadow ^ d; m_shadow = v; end
    endcase
    return {a, 32'(v), m_shadow};
  endfunction

  // Drive one command and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input bit who, input logic [1:0] op, input logic [LW-1:0] d);
    bit got = 1'b0;
    @(negedge clk);
    if (who) begin b_valid = 1'b1; b_op = op; b_data = d; end
    else     begin a_valid = 1'b1; a_op = op; a_data = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if ((who ? b_ready : a_ready) === 1'b1) begin
        got = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_timeout: requester %0d op %0d never accepted (required accept within 40 cycles)", who, op);
      a_valid = 1'b0; b_valid = 1'b0;
    end else begin
      exp_q.push_back(model_cmd(op, d));
      m_last_b = who;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 'h1; b_data = 'h2;
    repeat (2) @(negedge clk); #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: a=%b b=%b required 0 0", a_ready, b_ready);
    end
    n_checks++;
    if (chipselect !== 1'b0 || write_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_bus: cs=%b wn=%b required 0 1", chipselect, write_n);
    end
    n_checks++;
    if (shadow !== '0 || busy !== 1'b0 || address !== 3'd0 || writedata !== 32'd0) begin
      n_fail++; $display("FAIL reset_regs: shadow=%h busy=%b addr=%0d wd=%h required all 0", shadow, busy, address, writedata);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL first_grant: a=%b b=%b required 1 0", a_ready, b_ready);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || chipselect !== 1'b0) begin
      n_fail++; $display("FAIL dropped_valid: busy=%b cs=%b required 0 0", busy, chipselect);
    end
  endtask

  task automatic test_single;
    logic [W-1:0] e;
    send(1'b0, 2'd0, 18'h2AAAA);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== e[W-1 -: 3] ||
        writedata !== 32'h0002AAAA || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_strobe: cs=%b wn=%b addr=%0d wd=%h rdy=%b required 1 0 %0d %h 0",
                         chipselect, write_n, address, writedata, a_ready, e[W-1 -: 3], e[LW +: 32]);
    end
    @(negedge clk);
    n_checks++;
    if (shadow !== e[LW-1:0] || busy !== 1'b1 || chipselect !== 1'b0 || write_n !== 1'b1) begin
      n_fail++; $display("FAIL single_after: shadow=%h busy=%b cs=%b wn=%b required %h 1 0 1",
                         shadow, busy, chipselect, write_n, e[LW-1:0]);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_gap: busy=%b required 1", busy); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_set_clear;
    logic [1:0]    ops[3]  = '{2'd0, 2'd1, 2'd2};
    logic [LW-1:0] dats[3] = '{18'h0, 18'h000F0, 18'h00030};
    logic [2:0]    addrs[3] = '{3'd0, 3'd4, 3'd5};
    logic [LW-1:0] shs[3]  = '{18'h0, 18'h000F0, 18'h000C0};
    logic [W-1:0]  e;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, ops[i], dats[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (chipselect !== 1'b1 || write_n !== 1'b0 || address !== addrs[i] || writedata !== e[LW +: 32]) begin
        n_fail++; $display("FAIL setclr_strobe%0d: cs=%b wn=%b addr=%0d wd=%h required 1 0 %0d %h",
                           i, chipselect, write_n, address, writedata, addrs[i], e[LW +: 32]);
      end
      @(negedge clk);
      n_checks++;
      if (shadow !== shs[i] || shadow !== e[LW-1:0]) begin
        n_fail++; $display("FAIL setclr_shadow%0d: shadow=%h required %h", i, shadow, shs[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_toggle;
    logic [W-1:0] e;
    send(1'b0, 2'd3, 18'h3FFFF);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (chipselect !== 1'b1 || address !== 3'd0 || writedata !== 32'h0003FF3F || writedata !== e[LW +: 32]) begin
      n_fail++; $display("FAIL toggle_strobe: cs=%b addr=%0d wd=%h required 1 0 0003ff3f", chipselect, address, writedata);
    end
    @(negedge clk);
    n_checks++;
    if (shadow !== 18'h3FF3F) begin n_fail++; $display("FAIL toggle_shadow: shadow=%h required 3ff3f", shadow); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit got = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_op = 2'd0; a_data = 18'h15555;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (a_ready === 1'b1) begin got = 1'b1; @(posedge clk); end
      else @(negedge clk);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL resetmid_accept: a_ready never high (required within 20 cycles)"); end
    #1;
    n_checks++;
    if (chipselect !== 1'b1) begin n_fail++; $display("FAIL resetmid_write: cs=%b required 1", chipselect); end
    #1; reset_n = 1'b0; #1;
    n_checks++;
    if (chipselect !== 1'b0 || write_n !== 1'b1 || shadow !== '0 || busy !== 1'b0 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL resetmid_async: cs=%b wn=%b shadow=%h busy=%b rdy=%b required 0 1 0 0 0",
                         chipselect, write_n, shadow, busy, a_ready);
    end
    m_shadow = '0; m_last_b = 1'b1;
    @(negedge clk); reset_n = 1'b1; #1;
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL resetmid_reaccept: a_ready=%b required 1", a_ready); end
    void'(model_cmd(2'd0, 18'h15555));
    m_last_b = 1'b0;
    @(posedge clk); #1; a_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (chipselect !== 1'b1 || address !== 3'd0 || writedata !== 32'h00015555) begin
      n_fail++; $display("FAIL resetmid_strobe: cs=%b addr=%0d wd=%h required 1 0 00015555", chipselect, address, writedata);
    end
    @(negedge clk);
    n_checks++;
    if (shadow !== m_shadow) begin n_fail++; $display("FAIL resetmid_shadow: shadow=%h required %h", shadow, m_shadow); end
  endtask

  // Two requesters issuing n random commands each; max_delay 0 keeps both valids high.
  task automatic test_stream(input string name, input int n, input int max_delay);
    logic [1:0]    aop[$], bop[$];
    logic [LW-1:0] ad[$], bd[$];
    int a_idx = 0, b_idx = 0, a_wait = 0, b_wait = 0, a_rdy = 0, b_rdy = 0;
    int cyc = 0, last_acc = -100, last_strobe = -1, next_ok = 0;
    bit sh_pend = 1'b0, want_b;
    logic [W-1:0]  e;
    logic [LW-1:0] sh_exp = '0;
    for (int i = 0; i < n; i++) begin
      aop.push_back(2'($urandom_range(0, 3))); ad.push_back(LW'($urandom_range(0, (1 << LW) - 1)));
      bop.push_back(2'($urandom_range(0, 3))); bd.push_back(LW'($urandom_range(0, (1 << LW) - 1)));
    end
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    while ((a_idx < n || b_idx < n || exp_q.size() != 0 || sh_pend) && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (sh_pend) begin
        sh_pend = 1'b0;
        n_checks++;
        if (shadow !== sh_exp) begin n_fail++; $display("FAIL %s_shadow: cycle %0d shadow=%h required %h", name, cyc, shadow, sh_exp); end
      end
      if (chipselect === 1'b1 && write_n === 1'b0) begin
        n_checks++;
        if (exp_q.size() == 0 || cyc != last_acc + 1) begin
          n_fail++; $display("FAIL %s_strobe_timing: strobe at cycle %0d, required at %0d", name, cyc, last_acc + 1);
        end else begin
          e = exp_q.pop_front();
          if (address !== e[W-1 -: 3] || writedata !== e[LW +: 32]) begin
            n_fail++; $display("FAIL %s_strobe: addr=%0d wd=%h required %0d %h", name, address, writedata, e[W-1 -: 3], e[LW +: 32]);
          end
          sh_exp = e[LW-1:0]; sh_pend = 1'b1;
          if (max_delay == 0 && last_strobe >= 0) begin
            n_checks++;
            if (cyc - last_strobe != 2 + GAP) begin
              n_fail++; $display("FAIL %s_spacing: %0d cycles required %0d", name, cyc - last_strobe, 2 + GAP);
            end
          end
          last_strobe = cyc;
        end
      end
      if (a_wait > 0) a_wait--;
      if (b_wait > 0) b_wait--;
      a_valid = (a_idx < n && a_wait == 0);
      b_valid = (b_idx < n && b_wait == 0);
      if (a_idx < n) begin a_op = aop[a_idx]; a_data = ad[a_idx]; end
      if (b_idx < n) begin b_op = bop[b_idx]; b_data = bd[b_idx]; end
      #1;
      want_b = (a_valid && b_valid) ? !m_last_b : b_valid;
      if (a_ready === 1'b1 || b_ready === 1'b1) begin
        n_checks++;
        if ((a_ready === 1'b1 && b_ready === 1'b1) || b_ready !== want_b || cyc < next_ok || !(a_valid || b_valid)) begin
          n_fail++; $display("FAIL %s_grant: cycle %0d a_ready=%b b_ready=%b required b=%b earliest %0d",
                             name, cyc, a_ready, b_ready, want_b, next_ok);
        end else begin
          if (want_b) begin
            exp_q.push_back(model_cmd(bop[b_idx], bd[b_idx]));
            b_idx++; b_rdy++; b_wait = $urandom_range(0, max_delay); m_last_b = 1'b1;
          end else begin
            exp_q.push_back(model_cmd(aop[a_idx], ad[a_idx]));
            a_idx++; a_rdy++; a_wait = $urandom_range(0, max_delay); m_last_b = 1'b0;
          end
          last_acc = cyc; next_ok = cyc + 2 + GAP;
        end
      end else if ((a_valid || b_valid) && cyc >= next_ok) begin
        n_checks++; n_fail++;
        $display("FAIL %s_stall: cycle %0d valid pending but no ready (required accept)", name, cyc);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++;
    if (cyc >= 4000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_timeout: %0d strobes outstanding after %0d cycles (required 0)", name, exp_q.size(), cyc);
    end
    n_checks++;
    if (a_rdy != n || b_rdy != n) begin
      n_fail++; $display("FAIL %s_ready_count: a=%0d b=%0d required %0d each", name, a_rdy, b_rdy, n);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_set_clear();
    test_toggle();
    test_reset_mid();
    test_stream("contention", 4, 0);
    test_stream("random", 24, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
